// File: rtl/mips_cpu_hilo_seq_unit.sv
// Multi-cycle HI/LO unit: shift-add multiplier, restoring divider and MFHI/MFLO read port with stall.
// Optional divide-by-zero flag behaviour selected by MIPS_HILO_DIV_ZERO_FLAG_EN.
module mips_cpu_hilo_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    input  logic             rd_en,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, opb_q;
    logic             mul_q, neg_q, neg_r_q, zdiv_q;

    logic             accept, is_muldiv, is_mult, a_neg, b_neg, b_zero, skip_run;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod;

    assign is_muldiv = ~op[2];
    assign is_mult   = op[0];
    assign a_neg     = op[1] & a[WIDTH-1];
    assign b_neg     = op[1] & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;
    assign b_zero    = (b == '0);

    assign busy    = (state_q != IDLE);
    assign ready   = ~busy;
    assign accept  = start & ~busy;
    assign stall   = rd_en & busy;
    assign rd_data = rd_sel ? hi : lo;

`ifdef MIPS_HILO_DIV_ZERO_FLAG_EN
    assign skip_run = ~is_mult & b_zero;
`else
    assign skip_run = 1'b0;
`endif

    // Multiply step: conditional add of the multiplicand, then shift {rem,quo} right.
    assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: shift the next dividend bit into the partial remainder.
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign prod      = {rem_q, quo_q};

    // NOTE: default assignments first so every path drives state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_muldiv) state_d = skip_run ? FIX : RUN;
            RUN:     if (count_q == LAST_STEP) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            opb_q   <= '0;
            count_q <= '0;
            mul_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            zdiv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (accept) begin
                        case (op)
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                rem_q   <= '0;
                                quo_q   <= is_mult ? b_mag : a_mag;
                                opb_q   <= is_mult ? a_mag : b_mag;
                                mul_q   <= is_mult;
                                neg_q   <= a_neg ^ b_neg;
                                neg_r_q <= a_neg;
                                zdiv_q  <= ~is_mult & b_zero;
                            end
                            3'b100:  hi <= a;
                            3'b101:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count_q <= count_q + 1'b1;
                    if (mul_q) begin
                        rem_q <= mul_sum[WIDTH:1];
                        quo_q <= {mul_sum[0], quo_q[WIDTH-1:1]};
                    end else if (div_ge) begin
                        rem_q <= div_shift[WIDTH-1:0] - opb_q;
                        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q <= div_shift[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
`ifdef MIPS_HILO_DIV_ZERO_FLAG_EN
                    if (!zdiv_q) begin
`else
                    begin
`endif
                        if (mul_q) begin
                            {hi, lo} <= neg_q ? -prod : prod;
                        end else begin
                            // A zero divisor leaves an all-ones quotient regardless of signs.
                            lo <= (neg_q && !zdiv_q) ? -quo_q : quo_q;
                            hi <= neg_r_q ? -rem_q : rem_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MIPS_HILO_DIV_ZERO_FLAG_EN
    logic dz_q;

    always_ff @(posedge clk) begin
        if (reset)       dz_q <= 1'b0;
        else if (accept) dz_q <= is_muldiv & skip_run;
    end

    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_hilo_seq_unit.sv
// Scoreboard bench for mips_cpu_hilo_seq_unit: an arithmetic reference model pushes expected HI/LO,
// a monitor pops on each completed operation; honours MIPS_HILO_DIV_ZERO_FLAG_EN.
module tb_mips_cpu_hilo_seq_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        rd_en = 1'b0, rd_sel = 1'b0;
    logic        ready, busy, stall, div_zero;
    logic [31:0] rd_data, hi, lo;

    mips_cpu_hilo_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .busy(busy), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rd_data), .stall(stall), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

`ifdef MIPS_HILO_DIV_ZERO_FLAG_EN
    localparam bit FLAG = 1'b1;
`else
    localparam bit FLAG = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy_len;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0, n_errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;
    bit          hold_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: architectural result of one accepted request.
    task automatic model_issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               output exp_t e);
        longint      sx, sy, p;
        logic [63:0] up;
        int          blen;
        blen = 0;
        m_dz = 1'b0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0, 3'd2: begin
                blen = 33;
                if (y == 0) begin
                    if (FLAG) begin
                        m_dz = 1'b1;
                        blen = 1;
                    end else begin
                        m_hi = x;
                        m_lo = 32'hFFFF_FFFF;
                    end
                end else if (o == 3'd0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_lo = x;
                    m_hi = 32'd0;
                end else begin
                    m_lo = 32'(sx / sy);
                    m_hi = 32'(sx % sy);
                end
            end
            3'd1: begin
                up = {32'd0, x} * {32'd0, y};
                {m_hi, m_lo} = up;
                blen = 33;
            end
            3'd3: begin
                p = sx * sy;
                {m_hi, m_lo} = p;
                blen = 33;
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = m_dz;
        e.busy_len = blen;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!hold_rd) begin
            rd_en  = 1'($urandom_range(0, 1));
            rd_sel = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int   n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        if (!ready) begin
            check("ready_timeout", {31'd0, ready}, 32'd1);
            return;
        end
        model_issue(o, x, y, e);
        exp_q.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares on completion of each accepted request and checks the read port.
    bit          pend = 1'b0;
    int          busy_cnt = 0, rst_cnt = 0;
    logic [31:0] cur_hi = '0, cur_lo = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 1'b0;
                cur_hi = '0;
                cur_lo = '0;
                if (rst_cnt > 0) begin
                    check("reset_hi", hi, 32'd0);
                    check("reset_lo", lo, 32'd0);
                    check("reset_busy", {31'd0, busy}, 32'd0);
                    check("reset_div_zero", {31'd0, div_zero}, 32'd0);
                end
                rst_cnt++;
                continue;
            end
            rst_cnt = 0;
            if (pend) begin
                if (busy) begin
                    busy_cnt++;
                    check("stall_in_flight", {31'd0, stall}, {31'd0, rd_en});
                    check("hold_hi", hi, cur_hi);
                    check("hold_lo", lo, cur_lo);
                    if (busy_cnt > 64) begin
                        check("busy_timeout", 32'(busy_cnt), 32'd33);
                        pend = 1'b0;
                    end
                end else if (exp_q.size() == 0) begin
                    check("queue_empty", 32'(exp_q.size()), 32'd1);
                    pend = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("busy_len", 32'(busy_cnt), 32'(e.busy_len));
                    check("result_hi", hi, e.hi);
                    check("result_lo", lo, e.lo);
                    check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    cur_hi = e.hi;
                    cur_lo = e.lo;
                    pend = 1'b0;
                end
            end
            if (!busy && rd_en) begin
                check("rd_data", rd_data, rd_sel ? cur_hi : cur_lo);
                check("stall_idle", {31'd0, stall}, 32'd0);
            end
            if (start && ready) begin
                pend = 1'b1;
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        issue(3'd3, 32'hFFFF_FFFD, 32'd5);
        issue(3'd0, 32'd7, 32'd2);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd5, 32'h0000_1234, 32'd0);
        issue(3'd4, 32'hCAFE_F00D, 32'd9);

        // Interlock: read HI held across a MULT; a second request during busy must be ignored.
        hold_rd = 1'b1;
        rd_en = 1'b1;
        rd_sel = 1'b1;
        issue(3'd3, 32'd12345, 32'hFFFF_FFB3);
        repeat (5) tick();
        op = 3'd5; a = 32'hDEAD_BEEF; start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        issue(3'd6, 32'd1, 32'd1);
        hold_rd = 1'b0;

        issue(3'd0, 32'h0000_1357, 32'd0);
        issue(3'd2, 32'h8000_0005, 32'd0);
        issue(3'd7, 32'h1111_1111, 32'd0);
        issue(3'd4, 32'h0000_ABCD, 32'd0);

        // Abort a divide partway through RUN.
        issue(3'd0, $urandom, 32'd3);
        repeat (10) tick();
        reset = 1'b1;
        start = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        repeat (50) issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());

        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
